// File: rtl/sprite_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_arbiter_ctrl
//
// Overlays up to NUM_SPR 32x32 sprites, which share one sprite ROM, on a
// background video stream. Sprite positions are written into shadow registers
// at any time. They are copied to the active registers on frame_tick, so a
// sprite never moves in the middle of a frame and cannot tear.
//
// Pipeline (x/y/bg_rgb to rgb_out is exactly 2 clk):
//   stage 0 : hit test of every active sprite. The lowest index wins. The ROM
//             address is registered. It is held when no sprite is hit.
//   stage 1 : the miss flag, video_on and bg_rgb are delayed so that they
//             line up with rom_data, which the ROM returns one clk later.
//   stage 2 : combinational mux of rom_data and background. The transparent
//             colour shows background, not a lower-priority sprite.
//
// Optional feature: define SPRITE_COLLISION_EN to build a sticky coll_flag.
// It is set when two or more sprites overlap the current pixel, and cleared on
// frame_tick. Without the macro, coll_flag is tied to 0.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   x[10:0], y[9:0]         current pixel column / row
//   video_on, frame_tick    visible-area flag, start-of-frame pulse
//   upd_valid/upd_ready     position-update handshake
//   upd_id, upd_x, upd_y,   sprite index, new top-left corner, visibility
//   upd_en
//   rom_sel, rom_row,       address presented to the shared sprite ROM
//   rom_col
//   rom_data[11:0]          ROM colour, one clk after the address
//   bg_rgb[11:0]            background colour aligned with x/y
//   rgb_out[11:0]           final pixel colour
//   sprite_hit              rgb_out comes from a sprite this cycle
//   coll_flag               sticky collision indicator
// -----------------------------------------------------------------------------
module sprite_arbiter_ctrl #(
  parameter int          NUM_SPR    = 4,
  parameter logic [11:0] TRANSP_RGB = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic        upd_valid,
  input  logic [1:0]  upd_id,
  input  logic [10:0] upd_x,
  input  logic [9:0]  upd_y,
  input  logic        upd_en,
  output logic        upd_ready,
  output logic [4:0]  rom_row,
  output logic [4:0]  rom_col,
  output logic [1:0]  rom_sel,
  input  logic [11:0] rom_data,
  input  logic [11:0] bg_rgb,
  output logic [11:0] rgb_out,
  output logic        sprite_hit,
  output logic        coll_flag
);

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        en;
  } spr_t;

  spr_t shadow_q [NUM_SPR];
  spr_t active_q [NUM_SPR];

  // The shadow-to-active copy takes the frame_tick cycle. Updates stall
  // for that one cycle, so a write and the copy never collide.
  logic upd_fire;
  assign upd_ready = ~frame_tick;
  assign upd_fire  = upd_valid & upd_ready;

  // ---------------------------------------------------------------------------
  // Sprite register sets
  // ---------------------------------------------------------------------------
  // NOTE: these arrays are only NUM_SPR entries of flip-flops, not a RAM.
  // Resetting them is cheap, and reset must clear pending shadow updates, so
  // they sit in the reset branch. A real RAM should not be reset this way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // An id with no matching sprite matches no entry. It is accepted and
      // then dropped.
      for (int i = 0; i < NUM_SPR; i++) begin
        if (upd_fire && upd_id == 2'(i)) begin
          shadow_q[i] <= '{x: upd_x, y: upd_y, en: upd_en};
        end
      end
      if (frame_tick) begin
        active_q <= shadow_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 0: hit test and priority select
  // ---------------------------------------------------------------------------
  // The comparison is done in 12 bits, so a sprite near the right or bottom
  // edge does not wrap around to column/row 0.
  function automatic logic in_span(input logic [11:0] p, input logic [11:0] o);
    return (p >= o) && (p <= o + 12'd31);
  endfunction

  logic [NUM_SPR-1:0] cand;
  logic               hit_any;
  logic [1:0]         win_sel;
  logic [4:0]         win_row;
  logic [4:0]         win_col;

  // NOTE: every output of this block gets a default before the loop.
  // Otherwise a path that leaves it unassigned would infer a latch.
  always_comb begin
    cand    = '0;
    win_sel = '0;
    win_row = '0;
    win_col = '0;
    // Walk from the highest index down, so the lowest candidate is the last
    // one to write and therefore wins.
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (active_q[i].en && video_on &&
          in_span({1'b0, x}, {1'b0, active_q[i].x}) &&
          in_span({2'b00, y}, {2'b00, active_q[i].y})) begin
        cand[i] = 1'b1;
        win_sel = 2'(i);
        // Offsets are below 32, so only the low 5 bits of the difference matter.
        win_row = y[4:0] - active_q[i].y[4:0];
        win_col = x[4:0] - active_q[i].x[4:0];
      end
    end
  end

  assign hit_any = |cand;

  logic        miss_s0, von_s0;
  logic [11:0] bg_s0;

  // NOTE: all sequential state uses non-blocking assignments, so every
  // register samples values from before the edge, whatever the order of the
  // statements.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_sel <= '0;
      rom_row <= '0;
      rom_col <= '0;
      miss_s0 <= 1'b0;
      von_s0  <= 1'b0;
      bg_s0   <= '0;
    end else begin
      if (hit_any) begin
        rom_sel <= win_sel;
        rom_row <= win_row;
        rom_col <= win_col;
      end
      miss_s0 <= ~hit_any;
      von_s0  <= video_on;
      bg_s0   <= bg_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: align the flags and the background with rom_data
  // ---------------------------------------------------------------------------
  logic        miss_s1, von_s1;
  logic [11:0] bg_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_s1 <= 1'b0;
      von_s1  <= 1'b0;
      bg_s1   <= '0;
    end else begin
      miss_s1 <= miss_s0;
      von_s1  <= von_s0;
      bg_s1   <= bg_s0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: final colour mux
  // ---------------------------------------------------------------------------
  // rom_data is valid in this cycle, so the mux is combinational. This gives a
  // total latency of 2 clk. Reset clears von_s1, which forces the output to
  // black.
  assign sprite_hit = von_s1 & ~miss_s1 & (rom_data != TRANSP_RGB);
  assign rgb_out    = !von_s1    ? 12'h000  :
                      sprite_hit ? rom_data : bg_s1;

  // ---------------------------------------------------------------------------
  // Optional collision detector
  // ---------------------------------------------------------------------------
`ifdef SPRITE_COLLISION_EN
  logic multi_hit;
  logic coll_q;

  // A vector has two or more bits set exactly when clearing its lowest set
  // bit leaves something behind.
  assign multi_hit = |(cand & (cand - 1'b1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
    end else if (multi_hit) begin
      coll_q <= 1'b1;
    end else if (frame_tick) begin
      coll_q <= 1'b0;
    end
  end

  assign coll_flag = coll_q;
`else
  assign coll_flag = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sprite_arbiter_ctrl
//
// Self-checking bench for sprite_arbiter_ctrl. The bench plays the part of the
// synchronous sprite ROM. Its contents are a fixed function of the address,
// with optional transparent pixels. A behavioural model holds sprite positions
// as integer arrays and works out each pixel from the sprite rules: the
// lowest-index visible box that contains the pixel wins, and a transparent
// texel shows background. It then checks the ROM address right away and the
// colour two cycles later.
// -----------------------------------------------------------------------------
module tb_sprite_arbiter_ctrl;

  localparam int          NUM_SPR = 4;
  localparam logic [11:0] TRANSP  = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] x;
  logic [9:0]  y;
  logic        video_on, frame_tick, upd_valid, upd_en;
  logic [1:0]  upd_id;
  logic [10:0] upd_x;
  logic [9:0]  upd_y;
  logic        upd_ready;
  logic [4:0]  rom_row, rom_col;
  logic [1:0]  rom_sel;
  logic [11:0] rom_data = '0;
  logic [11:0] bg_rgb;
  logic [11:0] rgb_out;
  logic        sprite_hit, coll_flag;

  sprite_arbiter_ctrl #(.NUM_SPR(NUM_SPR), .TRANSP_RGB(TRANSP)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .video_on(video_on),
    .frame_tick(frame_tick), .upd_valid(upd_valid), .upd_id(upd_id),
    .upd_x(upd_x), .upd_y(upd_y), .upd_en(upd_en), .upd_ready(upd_ready),
    .rom_row(rom_row), .rom_col(rom_col), .rom_sel(rom_sel),
    .rom_data(rom_data), .bg_rgb(bg_rgb), .rgb_out(rgb_out),
    .sprite_hit(sprite_hit), .coll_flag(coll_flag)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // ROM contents and the ROM itself
  // ---------------------------------------------------------------------------
  bit force_transp = 0;
  bit transp_rand  = 0;

  function automatic logic [11:0] rom_val(input int sel, input int row, input int col);
    logic [1:0] s;
    logic [4:0] r, c;
    s = sel[1:0];
    r = row[4:0];
    c = col[4:0];
    if (force_transp) return TRANSP;
    if (transp_rand && ((r ^ c) & 5'd7) == 5'd0) return TRANSP;
    return {s, r, c} ^ 12'h5A5;
  endfunction

  always @(posedge clk) rom_data <= rom_val(int'(rom_sel), int'(rom_row), int'(rom_col));

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int sh_x[NUM_SPR], sh_y[NUM_SPR], ac_x[NUM_SPR], ac_y[NUM_SPR];
  bit sh_en[NUM_SPR], ac_en[NUM_SPR];
  int m_sel, m_row, m_col;
  bit m_coll;

  typedef struct {
    bit          von;
    int          win;
    int          row;
    int          col;
    logic [11:0] bg;
  } pix_t;

  pix_t prev;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SPR; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 0;
      ac_x[i] = 0; ac_y[i] = 0; ac_en[i] = 0;
    end
    m_sel = 0; m_row = 0; m_col = 0; m_coll = 0;
    prev = '{von: 0, win: -1, row: 0, col: 0, bg: '0};
  endtask

  task automatic set_idle();
    x = '0; y = '0; video_on = 0; frame_tick = 0; upd_valid = 0;
    upd_id = '0; upd_x = '0; upd_y = '0; upd_en = 0; bg_rgb = '0;
  endtask

  // One clock with the inputs the caller has set. It checks the handshake
  // before the edge, the ROM address and collision flag after it, and the
  // colour of the pixel presented one call earlier.
  task automatic cycle();
    pix_t cur;
    int   cnt;
    logic [11:0] v, exp_rgb;
    bit   exp_hit;
    #1;
    check("upd_ready", {31'b0, upd_ready}, {31'b0, !frame_tick});

    cur = '{von: video_on, win: -1, row: 0, col: 0, bg: bg_rgb};
    cnt = 0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (ac_en[i] && video_on &&
          int'(x) >= ac_x[i] && int'(x) <= ac_x[i] + 31 &&
          int'(y) >= ac_y[i] && int'(y) <= ac_y[i] + 31) begin
        cnt++;
        if (cur.win < 0) begin
          cur.win = i;
          cur.row = int'(y) - ac_y[i];
          cur.col = int'(x) - ac_x[i];
        end
      end
    end
    if (cur.win >= 0) begin
      m_sel = cur.win; m_row = cur.row; m_col = cur.col;
    end
`ifdef SPRITE_COLLISION_EN
    if (cnt >= 2) m_coll = 1;
    else if (frame_tick) m_coll = 0;
`endif
    if (frame_tick) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        ac_x[i] = sh_x[i]; ac_y[i] = sh_y[i]; ac_en[i] = sh_en[i];
      end
    end else if (upd_valid && int'(upd_id) < NUM_SPR) begin
      sh_x[upd_id] = int'(upd_x); sh_y[upd_id] = int'(upd_y); sh_en[upd_id] = upd_en;
    end

    @(posedge clk);
    #1;
    check("rom_sel", {30'b0, rom_sel}, 32'(m_sel));
    check("rom_row", {27'b0, rom_row}, 32'(m_row));
    check("rom_col", {27'b0, rom_col}, 32'(m_col));
    check("coll_flag", {31'b0, coll_flag}, {31'b0, m_coll});

    exp_hit = 0;
    exp_rgb = prev.bg;
    if (!prev.von) begin
      exp_rgb = 12'h000;
    end else if (prev.win >= 0) begin
      v = rom_val(prev.win, prev.row, prev.col);
      if (v != TRANSP) begin
        exp_rgb = v;
        exp_hit = 1;
      end
    end
    check("rgb_out", {20'b0, rgb_out}, {20'b0, exp_rgb});
    check("sprite_hit", {31'b0, sprite_hit}, {31'b0, exp_hit});
    prev = cur;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    #2;
    model_reset();
    check("rst rom_sel", {30'b0, rom_sel}, 32'd0);
    check("rst rom_row", {27'b0, rom_row}, 32'd0);
    check("rst rom_col", {27'b0, rom_col}, 32'd0);
    check("rst rgb_out", {20'b0, rgb_out}, 32'd0);
    check("rst sprite_hit", {31'b0, sprite_hit}, 32'd0);
    check("rst coll_flag", {31'b0, coll_flag}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    #1;
    check("rst upd_ready", {31'b0, upd_ready}, 32'd1);
  endtask

  task automatic update(input int id, input int ux, input int uy, input bit en);
    set_idle();
    upd_valid = 1; upd_id = 2'(id); upd_x = 11'(ux); upd_y = 10'(uy); upd_en = en;
    cycle();
  endtask

  task automatic tick();
    set_idle();
    frame_tick = 1;
    cycle();
  endtask

  task automatic pixel(input int px, input int py, input logic [11:0] bg);
    set_idle();
    x = 11'(px); y = 10'(py); video_on = 1; bg_rgb = bg;
    cycle();
  endtask

  task automatic flush();
    set_idle();
    cycle();
    cycle();
  endtask

  initial begin
    do_reset();

    // A shadow update is invisible until frame_tick, then it is shown.
    update(0, 100, 50, 1);
    pixel(100, 50, 12'h123);
    tick();
    pixel(100, 50, 12'h234);
    flush();

    // Corner of the 32x32 box, then one pixel past it.
    pixel(131, 81, 12'h345);
    pixel(132, 82, 12'h456);
    flush();

    // Two sprites overlap. The lower index wins; a transparent texel shows
    // background.
    update(1, 200, 200, 1);
    update(0, 200, 200, 1);
    tick();
    pixel(205, 210, 12'h567);
    pixel(206, 211, 12'h678);
    force_transp = 1;
    flush();
    pixel(205, 210, 12'h789);
    flush();
    force_transp = 0;
    tick();

    // A sprite at the right edge does not wrap to column 0.
    update(2, 2040, 1000, 1);
    tick();
    pixel(0, 1000, 12'h89A);
    pixel(2047, 1000, 12'h9AB);
    flush();

    // An update held across frame_tick is accepted one cycle later and is not
    // shown until the next tick.
    set_idle();
    upd_valid = 1; upd_id = 2'd3; upd_x = 11'd300; upd_y = 10'd300; upd_en = 1;
    frame_tick = 1;
    cycle();
    frame_tick = 0;
    cycle();
    pixel(300, 300, 12'hABC);
    flush();
    tick();
    pixel(300, 300, 12'hBCD);
    flush();

    // Reset in mid-frame discards a pending shadow update.
    update(0, 500, 400, 1);
    do_reset();
    tick();
    pixel(500, 400, 12'hCDE);
    flush();

    // Randomised traffic over a small screen region, so boxes are hit often.
    for (int n = 0; n < 2500; n++) begin
      set_idle();
      x          = 11'($urandom_range(0, 460));
      y          = 10'($urandom_range(0, 360));
      video_on   = ($urandom_range(0, 9) != 0);
      bg_rgb     = 12'($urandom);
      frame_tick = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        upd_valid = 1;
        upd_id    = 2'($urandom);
        upd_x     = 11'($urandom_range(0, 420));
        upd_y     = 10'($urandom_range(0, 330));
        upd_en    = ($urandom_range(0, 4) != 0);
      end
      if ($urandom_range(0, 199) == 0) transp_rand = ~transp_rand;
      cycle();
    end
    flush();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
